// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 3-stage pipeline control logic.
package pipeline_pkg;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } hctl_state_t;

  localparam logic [3:0]  REG_PC = 4'hF;
  localparam logic [31:0] NOP    = 32'hE320F000;

endpackage

// File: rtl/hazard_match.sv
// Flags when any valid decode source register equals the execute destination.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic [3:0] dec_rn,
  input  logic [3:0] dec_rm,
  input  logic [3:0] dec_rs,
  input  logic [2:0] dec_uses,
  input  logic [3:0] ex_rd,
  output logic       match
);

  // R15 reads come from the PC path, so they never depend on an in-flight load.
  logic rn_hit, rm_hit, rs_hit;

  assign rn_hit = dec_uses[0] && (dec_rn == ex_rd) && (dec_rn != REG_PC);
  assign rm_hit = dec_uses[1] && (dec_rm == ex_rd) && (dec_rm != REG_PC);
  assign rs_hit = dec_uses[2] && (dec_rs == ex_rd) && (dec_rs != REG_PC);
  assign match  = rn_hit || rm_hit || rs_hit;

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage stall/bubble sequencing, branch epoch tracking and stall counter.
// Handshake: mem_busy=1 freezes the whole pipe; execute keeps branch_taken high until mem_busy drops.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic [3:0]       dec_rn,
  input  logic [3:0]       dec_rm,
  input  logic [3:0]       dec_rs,
  input  logic [2:0]       dec_uses,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [3:0]       ex_rd,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic             sel_stall,
  output logic             stall_all,
  output logic             ex_bubble,
  output logic             branch_epoch,
  output logic             branch_ref,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] WAIT_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hctl_state_t state, nxt_state;
  logic [2:0]  wait_cnt, nxt_wait;
  logic        epoch, epoch_toggle;
  logic        match, hazard;
  logic        sel_stall_c, stall_all_c, ex_bubble_c;

  hazard_match u_match (
    .dec_rn   (dec_rn),
    .dec_rm   (dec_rm),
    .dec_rs   (dec_rs),
    .dec_uses (dec_uses),
    .ex_rd    (ex_rd),
    .match    (match)
  );

  assign hazard = dec_valid && ex_wr_en && ex_is_load && match;

  // Priority: memory wait, then branch redirect, then load-use sequencing.
  always_comb begin
    sel_stall_c  = 1'b0;
    stall_all_c  = 1'b0;
    ex_bubble_c  = 1'b0;
    epoch_toggle = 1'b0;
    nxt_state    = state;
    nxt_wait     = wait_cnt;
    if (mem_busy) begin
      sel_stall_c = 1'b1;
      stall_all_c = 1'b1;
    end else if (branch_taken) begin
      epoch_toggle = 1'b1;
      nxt_state    = RUN;
      nxt_wait     = 3'd0;
    end else if (state == LOAD_WAIT) begin
      sel_stall_c = 1'b1;
      ex_bubble_c = 1'b1;
      nxt_wait    = wait_cnt - 3'd1;
      if (wait_cnt == 3'd1) nxt_state = RUN;
    end else if (hazard) begin
      sel_stall_c = 1'b1;
      ex_bubble_c = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        nxt_wait  = WAIT_RELOAD;
        nxt_state = LOAD_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 3'd0;
      epoch     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= nxt_state;
      wait_cnt <= nxt_wait;
      if (epoch_toggle) epoch <= ~epoch;
      if (sel_stall_c && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Strobes are forced low while reset is held, whatever the inputs do.
  assign sel_stall    = rst_n && sel_stall_c;
  assign stall_all    = rst_n && stall_all_c;
  assign ex_bubble    = rst_n && ex_bubble_c;
  assign branch_epoch = epoch;
  assign branch_ref   = epoch;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: one instance with single-cycle load stalls, one with 3-cycle stalls and a 4-bit counter.
module tb_hazard_controller;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid;
  logic [3:0] dec_rn, dec_rm, dec_rs;
  logic [2:0] dec_uses;
  logic       ex_wr_en, ex_is_load;
  logic [3:0] ex_rd;
  logic       mem_busy, branch_taken;

  logic        a_sel, a_all, a_bub, a_be, a_br;
  logic [15:0] a_cnt;
  logic        b_sel, b_all, b_bub, b_be, b_br;
  logic [3:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_rs(dec_rs), .dec_uses(dec_uses), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .sel_stall(a_sel), .stall_all(a_all), .ex_bubble(a_bub),
    .branch_epoch(a_be), .branch_ref(a_br), .stall_cnt(a_cnt)
  );

  hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_rs(dec_rs), .dec_uses(dec_uses), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .sel_stall(b_sel), .stall_all(b_all), .ex_bubble(b_bub),
    .branch_epoch(b_be), .branch_ref(b_br), .stall_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 1'b0; dec_rn = 4'd0; dec_rm = 4'd0; dec_rs = 4'd0; dec_uses = 3'b000;
    ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = 4'd0; mem_busy = 1'b0; branch_taken = 1'b0;
  endtask

  // LDR r3 in execute, decode reads r3 as Rn.
  task automatic load_use();
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd3;
    dec_valid = 1'b1; dec_rn = 4'd3; dec_uses = 3'b001;
  endtask

  task automatic strobes(input string tag, input logic sel, input logic all, input logic bub,
                         input logic use_b);
    if (use_b) begin
      chk({tag, "_b_sel"}, 32'(b_sel), 32'(sel));
      chk({tag, "_b_all"}, 32'(b_all), 32'(all));
      chk({tag, "_b_bub"}, 32'(b_bub), 32'(bub));
    end else begin
      chk({tag, "_a_sel"}, 32'(a_sel), 32'(sel));
      chk({tag, "_a_all"}, 32'(a_all), 32'(all));
      chk({tag, "_a_bub"}, 32'(a_bub), 32'(bub));
    end
  endtask

  task automatic epochs(input string tag, input logic e);
    chk({tag, "_a_be"}, 32'(a_be), 32'(e));
    chk({tag, "_a_br"}, 32'(a_br), 32'(e));
    chk({tag, "_b_be"}, 32'(b_be), 32'(e));
    chk({tag, "_b_br"}, 32'(b_br), 32'(e));
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    strobes("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    strobes("rst", 1'b0, 1'b0, 1'b0, 1'b1);
    epochs("rst", 1'b0);
    chk("rst_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst_b_cnt", 32'(b_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Load-use: one stall cycle on A, three on B; execute receives a bubble after the first.
    load_use(); #1;
    strobes("lu1", 1'b1, 1'b0, 1'b1, 1'b0);
    strobes("lu1", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    ex_wr_en = 1'b0; ex_is_load = 1'b0; #1;
    strobes("lu2", 1'b0, 1'b0, 1'b0, 1'b0);
    strobes("lu2", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    strobes("lu3", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    strobes("lu4", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lu_a_cnt", 32'(a_cnt), 32'd1);
    chk("lu_b_cnt", 32'(b_cnt), 32'd3);

    // Reset in the middle of a B load wait, with the hazard still presented.
    load_use(); #1;
    tick();
    chk("mid_b_state", 32'(u_b.state), 32'(LOAD_WAIT));
    #2 rst_n = 1'b0; #1;
    strobes("arst", 1'b0, 1'b0, 1'b0, 1'b1);
    strobes("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_b_cnt", 32'(b_cnt), 32'd0);
    chk("arst_a_cnt", 32'(a_cnt), 32'd0);
    epochs("arst", 1'b0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(u_b.state), 32'(RUN));
    strobes("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

    // No-hazard variants.
    load_use(); dec_rn = 4'hF; ex_rd = 4'hF; #1;
    strobes("r15", 1'b0, 1'b0, 1'b0, 1'b0);
    strobes("r15", 1'b0, 1'b0, 1'b0, 1'b1);
    load_use(); dec_uses = 3'b000; #1;
    strobes("nouse", 1'b0, 1'b0, 1'b0, 1'b1);
    load_use(); ex_is_load = 1'b0; #1;
    strobes("noload", 1'b0, 1'b0, 1'b0, 1'b1);
    load_use(); dec_rn = 4'd0; dec_rs = 4'd3; dec_uses = 3'b100; #1;
    strobes("rs_hit", 1'b1, 1'b0, 1'b1, 1'b0);
    idle_inputs(); #1;

    // Branch flush from epoch 0.
    branch_taken = 1'b1; #1;
    strobes("br", 1'b0, 1'b0, 1'b0, 1'b0);
    epochs("br_pre", 1'b0);
    tick();
    branch_taken = 1'b0; #1;
    epochs("br_post", 1'b1);
    strobes("br_post", 1'b0, 1'b0, 1'b0, 1'b1);

    // Memory wait dominates hazard and branch for 4 cycles.
    load_use(); branch_taken = 1'b1; mem_busy = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      strobes($sformatf("mw%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
      strobes($sformatf("mw%0d", i), 1'b1, 1'b1, 1'b0, 1'b1);
      epochs($sformatf("mw%0d", i), 1'b1);
      tick();
    end
    chk("mw_a_cnt", 32'(a_cnt), 32'd4);
    chk("mw_b_cnt", 32'(b_cnt), 32'd4);
    mem_busy = 1'b0; #1;
    strobes("rel_br", 1'b0, 1'b0, 1'b0, 1'b0);
    strobes("rel_br", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    epochs("rel_br", 1'b0);
    branch_taken = 1'b0; #1;
    strobes("rel_hz", 1'b1, 1'b0, 1'b1, 1'b0);
    strobes("rel_hz", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rel_a_cnt", 32'(a_cnt), 32'd5);
    chk("rel_b_cnt", 32'(b_cnt), 32'd5);

    // Branch in B's second stall cycle aborts the wait.
    idle_inputs(); #1;
    strobes("lw2", 1'b1, 1'b0, 1'b1, 1'b1);
    branch_taken = 1'b1; #1;
    strobes("lw_br", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    branch_taken = 1'b0; #1;
    chk("lw_br_state", 32'(u_b.state), 32'(RUN));
    epochs("lw_br", 1'b1);
    strobes("lw_after", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lw_b_cnt", 32'(b_cnt), 32'd5);

    // Saturation: 20 frozen cycles on top of 5.
    mem_busy = 1'b1; #1;
    for (int i = 0; i < 9; i++) tick();
    chk("sat_b_cnt9", 32'(b_cnt), 32'd14);
    for (int i = 0; i < 11; i++) tick();
    chk("sat_b_cnt", 32'(b_cnt), 32'hF);
    chk("sat_a_cnt", 32'(a_cnt), 32'd25);
    mem_busy = 1'b0; #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
